// File: rtl/pfd_sampled_if.sv
// Signal bundle between the sampled PFD and its surroundings.
// The PFD takes the slave view; whatever supplies ref/fb takes the master view.
interface pfd_sampled_if #(
  parameter int W = 8
) ();
  logic         ref_clk;
  logic         fb;
  logic         up;
  logic         dn;
  logic [W-1:0] err_width;
  logic         err_sign;
  logic         err_valid;
  logic         slip;
  logic         lock;

  modport master (
    output ref_clk, fb,
    input  up, dn, err_width, err_sign, err_valid, slip, lock
  );

  modport slave (
    input  ref_clk, fb,
    output up, dn, err_width, err_sign, err_valid, slip, lock
  );
endinterface

// File: rtl/pfd_sampled.sv
// Sampled tri-state phase-frequency detector with phase-error report,
// cycle-slip detection and lock indication.
//
//   state | meaning
//   IDLE  | no pending lead, waiting for the first edge
//   UP    | ref has led, counting lead cycles, up asserted
//   DN    | fb has led, counting lead cycles, dn asserted
//   BOTH  | both edges seen, up and dn held for MIN_ON cycles
module pfd_sampled #(
  parameter int SYNC_STAGES = 2,
  parameter int MIN_ON      = 2,
  parameter int W           = 8,
  parameter int LOCK_TOL    = 3,
  parameter int LOCK_CNT    = 16
) (
  input logic         clk,
  input logic         rst,
  pfd_sampled_if.slave bus
);

  localparam int HW = (MIN_ON > 1) ? $clog2(MIN_ON) : 1;
  localparam int LW = $clog2(LOCK_CNT + 1);

  typedef enum logic [1:0] {IDLE, UP, DN, BOTH} state_t;

  state_t                 state, state_nx;
  logic [SYNC_STAGES-1:0] ref_sync, fb_sync;
  logic                   ref_prev, fb_prev;
  logic                   re, fe;
  logic                   eff_r, eff_f;
  logic                   resolve;
  logic                   enter_both;
  logic                   sign_nx;
  logic                   slip_nx;
  logic [W-1:0]           width_nx;
  logic [W-1:0]           cnt, cnt_inc;
  logic [HW-1:0]          hold;
  logic                   pend_r, pend_f;
  logic [W-1:0]           err_width;
  logic                   err_sign, err_valid, slip, lock;
  logic [LW-1:0]          lock_cnt, lock_cnt_inc;

  assign re = ref_sync[SYNC_STAGES-1] & ~ref_prev;
  assign fe = fb_sync[SYNC_STAGES-1] & ~fb_prev;

  assign cnt_inc      = (cnt == {W{1'b1}}) ? cnt : cnt + 1'b1;
  assign lock_cnt_inc = (lock_cnt == LW'(LOCK_CNT)) ? lock_cnt : lock_cnt + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      ref_sync <= '0;
      fb_sync  <= '0;
      ref_prev <= 1'b0;
      fb_prev  <= 1'b0;
    end else begin
      ref_sync <= {ref_sync[SYNC_STAGES-2:0], bus.ref_clk};
      fb_sync  <= {fb_sync[SYNC_STAGES-2:0], bus.fb};
      ref_prev <= ref_sync[SYNC_STAGES-1];
      fb_prev  <= fb_sync[SYNC_STAGES-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Leaving BOTH behaves like IDLE, with edges caught during the window folded in.
  always_comb begin
    state_nx   = state;
    enter_both = 1'b0;
    sign_nx    = 1'b0;
    slip_nx    = 1'b0;
    width_nx   = '0;
    eff_r      = re | (pend_r & (state == BOTH));
    eff_f      = fe | (pend_f & (state == BOTH));
    resolve    = (state == IDLE) || ((state == BOTH) && (hold == '0));
    if (resolve) begin
      case ({eff_r, eff_f})
        2'b11: begin
          state_nx   = BOTH;
          enter_both = 1'b1;
        end
        2'b10:   state_nx = UP;
        2'b01:   state_nx = DN;
        default: state_nx = IDLE;
      endcase
    end else begin
      case (state)
        UP: begin
          if (fe) begin
            state_nx   = BOTH;
            enter_both = 1'b1;
            width_nx   = cnt_inc;
            sign_nx    = 1'b1;
          end else if (re) begin
            slip_nx = 1'b1;
          end
        end
        DN: begin
          if (re) begin
            state_nx   = BOTH;
            enter_both = 1'b1;
            width_nx   = cnt_inc;
          end else if (fe) begin
            slip_nx = 1'b1;
          end
        end
        default: state_nx = state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      hold   <= '0;
      pend_r <= 1'b0;
      pend_f <= 1'b0;
    end else begin
      if ((state_nx != state) && ((state_nx == UP) || (state_nx == DN))) cnt <= '0;
      else if ((state == UP) || (state == DN))                          cnt <= cnt_inc;

      if (enter_both)                           hold <= HW'(MIN_ON - 1);
      else if ((state == BOTH) && (hold != '0)) hold <= hold - 1'b1;

      if ((state == BOTH) && !resolve) begin
        pend_r <= pend_r | re;
        pend_f <= pend_f | fe;
      end else begin
        pend_r <= 1'b0;
        pend_f <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_width <= '0;
      err_sign  <= 1'b0;
      err_valid <= 1'b0;
      slip      <= 1'b0;
      lock_cnt  <= '0;
      lock      <= 1'b0;
    end else begin
      err_valid <= enter_both;
      slip      <= slip_nx;
      if (enter_both) begin
        err_width <= width_nx;
        err_sign  <= sign_nx;
      end
      // Lock follows the registered report, so it trails err_valid by one edge.
      if (slip) begin
        lock_cnt <= '0;
        lock     <= 1'b0;
      end else if (err_valid) begin
        if (err_width <= W'(LOCK_TOL)) begin
          lock_cnt <= lock_cnt_inc;
          lock     <= (lock_cnt_inc == LW'(LOCK_CNT));
        end else begin
          lock_cnt <= '0;
          lock     <= 1'b0;
        end
      end
    end
  end

  assign bus.up        = (state == UP) || (state == BOTH);
  assign bus.dn        = (state == DN) || (state == BOTH);
  assign bus.err_width = err_width;
  assign bus.err_sign  = err_sign;
  assign bus.err_valid = err_valid;
  assign bus.slip      = slip;
  assign bus.lock      = lock;

endmodule

// File: tb/tb_pfd_sampled.sv
// Directed bench for pfd_sampled: a default instance plus a W=4 instance
// sharing the same ref/fb stimulus for the saturation case.
module tb_pfd_sampled;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ref_clk = 1'b0;
  logic fb = 1'b0;

  int checks = 0;
  int errors = 0;

  int up_cyc = 0, dn_cyc = 0, ev_cnt = 0, slip_cnt = 0;
  int last_w = 0, last_s = 0;
  int u0, d0, e0, s0;

  pfd_sampled_if #(.W(8)) bus_m ();
  pfd_sampled_if #(.W(4)) bus_s ();

  assign bus_m.ref_clk = ref_clk;
  assign bus_m.fb      = fb;
  assign bus_s.ref_clk = ref_clk;
  assign bus_s.fb      = fb;

  pfd_sampled u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_m)
  );

  pfd_sampled #(.W(4)) u_sat (
    .clk (clk),
    .rst (rst),
    .bus (bus_s)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus_m.up)   up_cyc++;
    if (bus_m.dn)   dn_cyc++;
    if (bus_m.slip) slip_cnt++;
    if (bus_m.err_valid) begin
      ev_cnt++;
      last_w = int'(bus_m.err_width);
      last_s = int'(bus_m.err_sign);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic snap();
    u0 = up_cyc;
    d0 = dn_cyc;
    e0 = ev_cnt;
    s0 = slip_cnt;
  endtask

  // One comparison: leader rises, other input follows gap cycles later.
  task automatic run_cmp(input int gap, input bit ref_first);
    if (gap == 0) begin
      ref_clk = 1'b1;
      fb      = 1'b1;
    end else begin
      if (ref_first) ref_clk = 1'b1;
      else           fb      = 1'b1;
      tick(gap);
      if (ref_first) fb      = 1'b1;
      else           ref_clk = 1'b1;
    end
    tick(8);
    ref_clk = 1'b0;
    fb      = 1'b0;
    tick(4);
  endtask

  initial begin
    // reset state
    tick(3);
    check("rst_up",        int'(bus_m.up), 0);
    check("rst_dn",        int'(bus_m.dn), 0);
    check("rst_err_width", int'(bus_m.err_width), 0);
    check("rst_err_sign",  int'(bus_m.err_sign), 0);
    check("rst_err_valid", int'(bus_m.err_valid), 0);
    check("rst_slip",      int'(bus_m.slip), 0);
    check("rst_lock",      int'(bus_m.lock), 0);
    rst = 1'b0;
    tick(4);

    // ref leads by 5, with sync latency probe
    snap();
    ref_clk = 1'b1;
    tick(2);
    check("lat_up_early", int'(bus_m.up), 0);
    tick(1);
    check("lat_up_on", int'(bus_m.up), 1);
    tick(2);
    fb = 1'b1;
    tick(8);
    ref_clk = 1'b0;
    fb      = 1'b0;
    tick(4);
    check("lead_ref_up_cyc", up_cyc - u0, 7);
    check("lead_ref_dn_cyc", dn_cyc - d0, 2);
    check("lead_ref_valid",  ev_cnt - e0, 1);
    check("lead_ref_width",  last_w, 5);
    check("lead_ref_sign",   last_s, 1);

    // fb leads by 9
    snap();
    run_cmp(9, 1'b0);
    check("lead_fb_dn_cyc", dn_cyc - d0, 11);
    check("lead_fb_up_cyc", up_cyc - u0, 2);
    check("lead_fb_valid",  ev_cnt - e0, 1);
    check("lead_fb_width",  last_w, 9);
    check("lead_fb_sign",   last_s, 0);

    // coincident edges
    snap();
    last_w = 99;
    last_s = 1;
    run_cmp(0, 1'b1);
    check("coinc_up_cyc", up_cyc - u0, 2);
    check("coinc_dn_cyc", dn_cyc - d0, 2);
    check("coinc_valid",  ev_cnt - e0, 1);
    check("coinc_width",  last_w, 0);
    check("coinc_sign",   last_s, 0);

    // lock acquire and lose
    run_cmp(10, 1'b1);
    check("lock_after_wide", int'(bus_m.lock), 0);
    for (int i = 0; i < 15; i++) run_cmp(2, 1'b1);
    check("lock_after_15", int'(bus_m.lock), 0);
    run_cmp(2, 1'b1);
    check("lock_after_16", int'(bus_m.lock), 1);
    run_cmp(10, 1'b1);
    check("lock_lost_wide", int'(bus_m.lock), 0);
    run_cmp(2, 1'b1);
    check("lock_cnt_cleared", int'(bus_m.lock), 0);
    for (int i = 0; i < 15; i++) run_cmp(2, 1'b0);
    check("relock", int'(bus_m.lock), 1);

    // cycle slip: two ref edges with no fb between
    snap();
    ref_clk = 1'b1;
    tick(3);
    ref_clk = 1'b0;
    tick(3);
    ref_clk = 1'b1;
    tick(6);
    check("slip_count", slip_cnt - s0, 1);
    check("slip_lock",  int'(bus_m.lock), 0);
    fb = 1'b1;
    tick(8);
    ref_clk = 1'b0;
    fb      = 1'b0;
    tick(4);
    check("slip_resolve_sign", last_s, 1);

    // long lead: full width on W=8, saturated on W=4
    snap();
    run_cmp(40, 1'b1);
    check("long_width_w8",  last_w, 40);
    check("long_up_cyc",    up_cyc - u0, 42);
    check("sat_width_w4",   int'(bus_s.err_width), 15);

    // reset during UP
    ref_clk = 1'b1;
    tick(5);
    check("pre_rst_up", int'(bus_m.up), 1);
    rst     = 1'b1;
    ref_clk = 1'b0;
    tick(1);
    check("rst_mid_up",    int'(bus_m.up), 0);
    check("rst_mid_dn",    int'(bus_m.dn), 0);
    check("rst_mid_valid", int'(bus_m.err_valid), 0);
    check("rst_mid_width", int'(bus_m.err_width), 0);
    tick(2);
    rst = 1'b0;
    tick(4);
    check("post_rst_up", int'(bus_m.up), 0);
    check("post_rst_dn", int'(bus_m.dn), 0);

    // ref edge arriving inside the BOTH window
    snap();
    ref_clk = 1'b1;
    tick(2);
    ref_clk = 1'b0;
    tick(1);
    fb = 1'b1;
    tick(1);
    ref_clk = 1'b1;
    tick(1);
    fb = 1'b0;
    tick(2);
    check("both_win_up", int'(bus_m.up), 1);
    check("both_win_dn", int'(bus_m.dn), 1);
    tick(1);
    check("pend_exit_up", int'(bus_m.up), 1);
    check("pend_exit_dn", int'(bus_m.dn), 0);
    check("pend_first_width", last_w, 3);
    check("pend_first_sign",  last_s, 1);
    tick(2);
    fb = 1'b1;
    tick(8);
    ref_clk = 1'b0;
    fb      = 1'b0;
    tick(4);
    check("pend_second_width", last_w, 5);
    check("pend_valid_count",  ev_cnt - e0, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
